vector_pls_seq: RTL and testbench

Multi-beat, predicated vector load/store sequencer for the vector unit. It accepts one vector memory command per handshake and captures the vector operand and compare-register flags. It splits the vector into bus-width beats, each carrying byte enables derived from a selectable compare condition, then returns merged load data with a per-element register write mask. It sits between the vector issue stage and the vector memory port, and generalises the single-cycle PLS path to arbitrary vector and bus widths with backpressure.

---
 rtl/vector_pls_seq.sv | 203 ++++++++++++++++++++
 tb/tb_vector_pls_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_pls_seq.sv
// Multi-beat predicated vector load/store sequencer between vector issue and the memory port.
// Optional build macro VECTOR_PLS_BEAT_SKIP_EN: beats whose byte enables are all zero are not issued.
module vector_pls_seq #(
    parameter int NUM_ELEMS           = 8,
    parameter int ELEM_SIZE           = 16,
    parameter int ENABLES_PER_ELEMENT = 4,
    parameter int BUS_WIDTH           = 64,
    localparam int BEATS  = NUM_ELEMS * ELEM_SIZE / BUS_WIDTH,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic                                    cmd_store,
    input  logic [2:0]                              cmd_cond,
    input  logic [NUM_ELEMS*ELEM_SIZE-1:0]          a,
    input  logic [NUM_ELEMS*ENABLES_PER_ELEMENT-1:0] vcr_eq,
    input  logic [NUM_ELEMS*ENABLES_PER_ELEMENT-1:0] vcr_lt,
    input  logic [NUM_ELEMS*ENABLES_PER_ELEMENT-1:0] vcr_gt,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_we,
    output logic [BEAT_W-1:0]                       m_beat,
    output logic [BUS_WIDTH-1:0]                    m_data,
    output logic [BUS_WIDTH/8-1:0]                  m_byteen,
    input  logic                                    s_valid,
    input  logic [BUS_WIDTH-1:0]                    s_data,
    output logic                                    done,
    output logic [NUM_ELEMS*ELEM_SIZE-1:0]          y,
    output logic [NUM_ELEMS*ENABLES_PER_ELEMENT-1:0] write_mask
);

    localparam int V      = NUM_ELEMS * ELEM_SIZE;
    localparam int E      = NUM_ELEMS * ENABLES_PER_ELEMENT;
    localparam int NBYTES = V / 8;
    localparam int EPB    = ENABLES_PER_ELEMENT / (ELEM_SIZE / 8);
    localparam int BB     = BUS_WIDTH / 8;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEAT_END = CNT_W'(BEATS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_ALWAYS = 3'b000;
    localparam logic [2:0] C_EQ     = 3'b001;
    localparam logic [2:0] C_LT     = 3'b010;
    localparam logic [2:0] C_GT     = 3'b011;
    localparam logic [2:0] C_LE     = 3'b100;
    localparam logic [2:0] C_GE     = 3'b101;
    localparam logic [2:0] C_NE     = 3'b110;

    logic [1:0]        r_state;
    logic              r_store;
    logic [V-1:0]      r_a;
    logic [NBYTES-1:0] r_byteen;
    logic [CNT_W-1:0]  r_beat;
    logic [CNT_W-1:0]  r_rsp_beat;
    logic [CNT_W-1:0]  r_outstanding;
    logic [V-1:0]      r_y;
    logic [E-1:0]      r_wmask;

    logic [E-1:0]      w_en;
    logic [NBYTES-1:0] w_byteen;
    logic [CNT_W-1:0]  w_first;
    logic [CNT_W-1:0]  w_next_issue;
    logic [CNT_W-1:0]  w_next_rsp;
    logic [CNT_W-1:0]  w_out_next;
    logic              w_issue;
    logic              w_rsp;
    int                w_issue_slice;
    int                w_rsp_slice;
    logic [BB-1:0]     w_rsp_be;
    logic [BUS_WIDTH-1:0] w_rsp_data;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_en = '0;
        case (cmd_cond)
            C_ALWAYS: w_en = '1;
            C_EQ:     w_en = vcr_eq;
            C_LT:     w_en = vcr_lt;
            C_GT:     w_en = vcr_gt;
            C_LE:     w_en = vcr_lt | vcr_eq;
            C_GE:     w_en = vcr_gt | vcr_eq;
            C_NE:     w_en = ~vcr_eq;
            default:  w_en = '0;
        endcase
        for (int i = 0; i < NBYTES; i++) begin
            w_byteen[i] = |w_en[i*EPB +: EPB];
        end
    end

`ifdef VECTOR_PLS_BEAT_SKIP_EN
    // Lowest beat index >= start that carries at least one enabled byte, BEAT_END if none.
    function automatic logic [CNT_W-1:0] next_beat(input logic [NBYTES-1:0] be, input int start);
        next_beat = BEAT_END;
        for (int b = BEATS - 1; b >= 0; b--) begin
            if (b >= start && |be[(BEATS-1-b)*BB +: BB]) next_beat = CNT_W'(b);
        end
    endfunction
`endif

    always_comb begin
`ifdef VECTOR_PLS_BEAT_SKIP_EN
        w_first      = next_beat(w_byteen, 0);
        w_next_issue = next_beat(r_byteen, int'(r_beat) + 1);
        w_next_rsp   = next_beat(r_byteen, int'(r_rsp_beat) + 1);
`else
        w_first      = '0;
        w_next_issue = r_beat + CNT_W'(1);
        w_next_rsp   = r_rsp_beat + CNT_W'(1);
`endif
    end

    assign w_issue = (r_state == S_ISSUE) && m_ready;
    assign w_rsp   = s_valid && (r_state == S_ISSUE || r_state == S_WAIT) && (r_outstanding != '0);

    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue && !r_store) w_out_next = w_out_next + CNT_W'(1);
        if (w_rsp)               w_out_next = w_out_next - CNT_W'(1);
    end

    // Beat 0 is the most significant slice of both the data and the byte-enable vectors.
    always_comb begin
        w_issue_slice = BEATS - 1 - int'(r_beat);
        w_rsp_slice   = BEATS - 1 - int'(r_rsp_beat);
        w_rsp_be      = r_byteen[w_rsp_slice*BB +: BB];
        for (int i = 0; i < BB; i++) begin
            w_rsp_data[i*8 +: 8] = w_rsp_be[i] ? s_data[i*8 +: 8] : 8'h00;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_store       <= 1'b0;
            r_a           <= '0;
            r_byteen      <= '0;
            r_beat        <= '0;
            r_rsp_beat    <= '0;
            r_outstanding <= '0;
            r_y           <= '0;
            r_wmask       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_store       <= cmd_store;
                        r_a           <= a;
                        r_byteen      <= w_byteen;
                        r_wmask       <= cmd_store ? '0 : w_en;
                        r_y           <= '0;
                        r_outstanding <= '0;
                        if (w_first == BEAT_END) begin
                            r_state    <= S_DONE;
                            r_beat     <= '0;
                            r_rsp_beat <= '0;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_beat     <= w_first;
                            r_rsp_beat <= w_first;
                        end
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        if (w_next_issue == BEAT_END) begin
                            r_state <= (r_store || w_out_next == '0) ? S_DONE : S_WAIT;
                        end else begin
                            r_beat <= w_next_issue;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_out_next == '0) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_rsp) begin
                r_y[w_rsp_slice*BUS_WIDTH +: BUS_WIDTH] <= w_rsp_data;
                if (w_next_rsp != BEAT_END) r_rsp_beat <= w_next_rsp;
            end
            if (r_state == S_ISSUE || r_state == S_WAIT) r_outstanding <= w_out_next;
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign m_valid    = (r_state == S_ISSUE);
    assign m_we       = m_valid && r_store;
    assign m_beat     = m_valid ? r_beat[BEAT_W-1:0] : '0;
    assign m_data     = m_valid ? r_a[w_issue_slice*BUS_WIDTH +: BUS_WIDTH] : '0;
    assign m_byteen   = m_valid ? r_byteen[w_issue_slice*BB +: BB] : '0;
    assign done       = (r_state == S_DONE);
    assign y          = r_y;
    assign write_mask = r_wmask;

endmodule

// File: tb/tb_vector_pls_seq.sv
// Scoreboard bench for vector_pls_seq at default parameters (2 beats of 64 bits).
// Beat expectations are honoured with or without VECTOR_PLS_BEAT_SKIP_EN.
module tb_vector_pls_seq;

    localparam int V  = 128;
    localparam int E  = 32;
    localparam int BW = 64;
    localparam int BB = 8;
    localparam int NB = 16;

    localparam logic [2:0] C_ALWAYS = 3'd0;
    localparam logic [2:0] C_EQ     = 3'd1;
    localparam logic [2:0] C_LT     = 3'd2;
    localparam logic [2:0] C_GE     = 3'd5;
    localparam logic [2:0] C_NEVER  = 3'd7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_store = 1'b0;
    logic [2:0]    cmd_cond = 3'd0;
    logic [V-1:0]  a = '0;
    logic [E-1:0]  vcr_eq = '0;
    logic [E-1:0]  vcr_lt = '0;
    logic [E-1:0]  vcr_gt = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_we;
    logic [0:0]    m_beat;
    logic [BW-1:0] m_data;
    logic [BB-1:0] m_byteen;
    logic          s_valid = 1'b0;
    logic [BW-1:0] s_data = '0;
    logic          done;
    logic [V-1:0]  y;
    logic [E-1:0]  write_mask;

    vector_pls_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store), .cmd_cond(cmd_cond),
        .a(a), .vcr_eq(vcr_eq), .vcr_lt(vcr_lt), .vcr_gt(vcr_gt),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_beat(m_beat),
        .m_data(m_data), .m_byteen(m_byteen),
        .s_valid(s_valid), .s_data(s_data),
        .done(done), .y(y), .write_mask(write_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:0]    beat;
        logic          we;
        logic [BW-1:0] data;
        logic [BB-1:0] be;
        bit            chk_data;
    } beat_t;

    typedef struct {
        int           cyc;
        logic [V-1:0] y;
        logic [E-1:0] wm;
    } done_t;

    beat_t q_beat[$];
    done_t q_done[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [E-1:0] model_en(input logic [2:0] c, input logic [E-1:0] eq,
                                              input logic [E-1:0] lt, input logic [E-1:0] gt);
        case (c)
            3'd0:    return '1;
            3'd1:    return eq;
            3'd2:    return lt;
            3'd3:    return gt;
            3'd4:    return lt | eq;
            3'd5:    return gt | eq;
            3'd6:    return ~eq;
            default: return '0;
        endcase
    endfunction

    // Each 8-bit byte is covered by two consecutive compare flags.
    function automatic logic [NB-1:0] model_be(input logic [E-1:0] en);
        logic [NB-1:0] be;
        for (int k = 0; k < NB; k++) be[k] = en[2*k] | en[2*k+1];
        return be;
    endfunction

    function automatic bit beat_issued(input logic [NB-1:0] be, input int b);
`ifdef VECTOR_PLS_BEAT_SKIP_EN
        return be[(1-b)*BB +: BB] != '0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [BW-1:0] byte_mask(input logic [BB-1:0] be);
        logic [BW-1:0] m;
        for (int i = 0; i < BB; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Monitor: pops beat and completion expectations as the DUT produces them.
    beat_t         e_b;
    done_t         e_d;
    bit            stall_prev = 1'b0;
    logic [0:0]    st_beat;
    logic [BW-1:0] st_data;
    logic [BB-1:0] st_be;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_beat", m_beat, st_beat);
                check("stall_data", m_data, st_data);
                check("stall_byteen", m_byteen, st_be);
            end
            stall_prev = 1'b0;
            if (m_valid) begin
                if (!m_ready) begin
                    stall_prev = 1'b1;
                    st_beat    = m_beat;
                    st_data    = m_data;
                    st_be      = m_byteen;
                end else if (q_beat.size() == 0) begin
                    check("unexpected_beat", m_valid, 1'b0);
                end else begin
                    e_b = q_beat.pop_front();
                    check("beat_idx", m_beat, e_b.beat);
                    check("beat_we", m_we, e_b.we);
                    check("beat_byteen", m_byteen, e_b.be);
                    if (e_b.chk_data) check("beat_data", m_data, e_b.data);
                end
            end
            if (done) begin
                if (q_done.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e_d = q_done.pop_front();
                    check("done_cycle", cyc, e_d.cyc);
                    check("done_y", y, e_d.y);
                    check("done_write_mask", write_mask, e_d.wm);
                end
            end
        end
    end

    task automatic send(input logic st, input logic [2:0] c, input logic [V-1:0] av,
                        input logic [E-1:0] eq, input logic [E-1:0] lt, input logic [E-1:0] gt,
                        output int k);
        cmd_store = st;
        cmd_cond  = c;
        a         = av;
        vcr_eq    = eq;
        vcr_lt    = lt;
        vcr_gt    = gt;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done();
        int i = 0;
        while (q_done.size() != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("done_timeout", q_done.size(), 0);
        check("beats_drained", q_beat.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_store(input logic [2:0] c, input logic [V-1:0] av, input logic [E-1:0] eq,
                             input logic [E-1:0] lt, input logic [E-1:0] gt, input int stall);
        logic [E-1:0]  en;
        logic [NB-1:0] be;
        beat_t         eb;
        done_t         ed;
        int            n;
        int            k;
        en = model_en(c, eq, lt, gt);
        be = model_be(en);
        n  = 0;
        for (int b = 0; b < 2; b++) begin
            if (beat_issued(be, b)) begin
                eb.beat     = 1'(b);
                eb.we       = 1'b1;
                eb.data     = av[(1-b)*BW +: BW];
                eb.be       = be[(1-b)*BB +: BB];
                eb.chk_data = 1'b1;
                q_beat.push_back(eb);
                n++;
            end
        end
        m_ready = (stall == 0);
        send(1'b1, c, av, eq, lt, gt, k);
        ed.cyc = (n == 0) ? k : k + stall + n;
        ed.y   = '0;
        ed.wm  = '0;
        q_done.push_back(ed);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            m_ready = 1'b1;
        end
        wait_done();
    endtask

    task automatic run_load(input logic [2:0] c, input logic [E-1:0] eq, input logic [E-1:0] lt,
                            input logic [E-1:0] gt, input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                            input int lat);
        logic [E-1:0]  en;
        logic [NB-1:0] be;
        logic [V-1:0]  yexp;
        beat_t         eb;
        done_t         ed;
        int            n;
        int            k;
        en   = model_en(c, eq, lt, gt);
        be   = model_be(en);
        yexp = '0;
        n    = 0;
        for (int b = 0; b < 2; b++) begin
            if (beat_issued(be, b)) begin
                eb.beat     = 1'(b);
                eb.we       = 1'b0;
                eb.data     = '0;
                eb.be       = be[(1-b)*BB +: BB];
                eb.chk_data = 1'b0;
                q_beat.push_back(eb);
                yexp[(1-b)*BW +: BW] = ((n == 0) ? d0 : d1) & byte_mask(eb.be);
                n++;
            end
        end
        m_ready = 1'b1;
        send(1'b0, c, '0, eq, lt, gt, k);
        ed.cyc = (n == 0) ? k : k + lat + n;
        ed.y   = yexp;
        ed.wm  = en;
        q_done.push_back(ed);
        if (n > 0) begin
            repeat (lat) @(posedge clk);
            #1;
            for (int i = 0; i < n; i++) begin
                s_valid = 1'b1;
                s_data  = (i == 0) ? d0 : d1;
                @(posedge clk);
                #1;
            end
            s_valid = 1'b0;
        end
        wait_done();
    endtask

    function automatic logic [V-1:0] rand_v();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        beat_t eb;
        int    k;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_we", m_we, 1'b0);
        check("rst_m_beat", m_beat, 1'b0);
        check("rst_m_data", m_data, 64'h0);
        check("rst_m_byteen", m_byteen, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_y", y, 128'h0);
        check("rst_write_mask", write_mask, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Store, always: two full beats, done at T+3.
        run_store(C_ALWAYS, 128'h0001_0002_0003_0004_0005_0006_0007_0008, '0, '0, '0, 0);
        check("store_always_wmask", write_mask, 32'h0);

        // Store, eq on element 0 only.
        run_store(C_EQ, rand_v(), 32'h8000_0000, '0, '0, 0);

        // Load, ge with gt=0011 per element: only the low byte of each element survives.
        run_load(C_GE, '0, '0, 32'h3333_3333, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        check("load_ge_y", y, {8{16'h00FF}});
        check("load_ge_wmask", write_mask, 32'h3333_3333);

        // Store with m_ready held low for 4 cycles on beat 0.
        run_store(C_ALWAYS, rand_v(), '0, '0, '0, 4);

        // Load interrupted by reset after beat 0.
        eb.beat = 1'b0; eb.we = 1'b0; eb.data = '0; eb.be = 8'hFF; eb.chk_data = 1'b0;
        q_beat.push_back(eb);
        m_ready = 1'b1;
        send(1'b0, C_ALWAYS, '0, '0, '0, '0, k);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_byteen", m_byteen, 8'h00);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_y", y, 128'h0);
        check("mid_rst_write_mask", write_mask, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_y", y, 128'h0);
        check("late_rsp_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_beats", q_beat.size(), 0);
        @(posedge clk);
        #1;

        // Normal command after the reset.
        run_store(C_LT, rand_v(), '0, $urandom, '0, 0);

        // Load, never.
        run_load(C_NEVER, '1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        check("load_never_y", y, 128'h0);
        check("load_never_wmask", write_mask, 32'h0);

        // Every condition code with random flags, both directions.
        for (int c = 0; c < 8; c++) begin
            run_store(3'(c), rand_v(), $urandom, $urandom, $urandom, 0);
            run_load(3'(c), $urandom, $urandom, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1 + c % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL global_timeout observed=running expected=finished");
    end

endmodule
